// File: rtl/sparhixcel_pkg.sv
// rtl/sparhixcel_pkg.sv - shared FSM state type and counter-width helper for the round sequencer
package sparhixcel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_LOAD    = 3'd2,
        ST_READY   = 3'd3,
        ST_OPERATE = 3'd4,
        ST_DRAIN   = 3'd5,
        ST_DONE    = 3'd6
    } seq_state_e;

    // Bits needed to hold max_count itself (never less than one bit).
    function automatic int cnt_width(input int max_count);
        return (max_count < 2) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/phase_counter.sv
// rtl/phase_counter.sv - loadable down-counter flagging the last cycle of a phase
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset (count -> 0)
//   clear      synchronous clear (count -> 0), below rst
//   load       load load_value, below clear
//   load_value terminal count for the phase
//   dec        decrement by one (saturates at 0), below load
//   last       count == 1: the current enabled step is the final one
module phase_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             last
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign last = (count_q == WIDTH'(1));

endmodule

// File: rtl/sa_round_sequencer.sv
// rtl/sa_round_sequencer.sv - per-round clear/load/ready/operate/drain sequencer for a systolic array
//
// Ports:
//   clk_i, general_rst_i           clock, synchronous active-high reset
//   start_i, abort_i               job start pulse, job abort
//   filter_size_i, n_rounds_i      job configuration, latched at start
//   weight_valid_i, end_feature_i  weight beat available, last feature beat
//   rst_o, load_o, ready_o,
//   start_op_o                     array control (mutually exclusive)
//   rd_weight_ld_o, rd_feature_ld_o,
//   rd_rom_signals_ld_o            read requests
//   addrs_rom_signal_o             control-ROM address
//   round_o                        current round index
//   busy_o, done_o, err_o          status; done_o and err_o are 1-cycle pulses
//
// Every output is a flop loaded from the next-state decode, so output
// timing tracks the state register exactly.  load_o is weight_valid_i
// registered; a LOAD cycle with load_o=1 is one weight beat.
module sa_round_sequencer
    import sparhixcel_pkg::*;
#(
    parameter int N_ROWS_ARRAY        = 4,
    parameter int N_COLS_ARRAY        = 4,
    parameter int N                   = 3,
    parameter int SIG_ADDRS_WIDTH     = 10,
    parameter int COUNTER_ROUND_WIDTH = 3,
    parameter int READY_CYCLES        = 2
) (
    input  logic                           clk_i,
    input  logic                           general_rst_i,
    input  logic                           start_i,
    input  logic                           abort_i,
    input  logic [$clog2(N+1)-1:0]         filter_size_i,
    input  logic [COUNTER_ROUND_WIDTH-1:0] n_rounds_i,
    input  logic                           weight_valid_i,
    input  logic                           end_feature_i,
    output logic                           rst_o,
    output logic                           load_o,
    output logic                           ready_o,
    output logic                           start_op_o,
    output logic                           rd_weight_ld_o,
    output logic                           rd_feature_ld_o,
    output logic                           rd_rom_signals_ld_o,
    output logic [SIG_ADDRS_WIDTH-1:0]     addrs_rom_signal_o,
    output logic [COUNTER_ROUND_WIDTH-1:0] round_o,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           err_o
);

    localparam int FS_W    = $clog2(N + 1);
    localparam int LOAD_W  = cnt_width(N * N_COLS_ARRAY);
    localparam int DRAIN_W = cnt_width(N_ROWS_ARRAY + N);
    localparam int READY_W = cnt_width(READY_CYCLES);

    seq_state_e state_q;
    seq_state_e state_next;

    logic [FS_W-1:0]                fs_q;
    logic [COUNTER_ROUND_WIDTH-1:0] rounds_q;

    logic cfg_ok;
    logic start_accept;
    logic round_step;
    logic more_rounds;

    logic cnt_clear;
    logic load_cnt_load, load_cnt_last;
    logic ready_cnt_load, ready_cnt_last;
    logic drain_cnt_load, drain_cnt_last;

    logic [LOAD_W-1:0]  load_total;
    logic [DRAIN_W-1:0] drain_total;

    assign cfg_ok       = (filter_size_i != '0) && (filter_size_i <= FS_W'(N));
    assign start_accept = (state_q == ST_IDLE) && start_i && cfg_ok;
    assign more_rounds  = (round_o < (rounds_q - COUNTER_ROUND_WIDTH'(1)));
    assign round_step   = (state_q == ST_DRAIN) && (state_next == ST_CLEAR);

    assign load_total  = LOAD_W'(32'(fs_q) * 32'(N_COLS_ARRAY));
    assign drain_total = DRAIN_W'(32'(N_ROWS_ARRAY) + 32'(fs_q));

    // Next state; abort overrides every other transition out of a busy state.
    always_comb begin
        state_next = state_q;
        case (state_q)
            ST_IDLE:    if (start_accept) state_next = ST_CLEAR;
            ST_CLEAR:   state_next = ST_LOAD;
            ST_LOAD:    if (load_o && load_cnt_last) state_next = ST_READY;
            ST_READY:   if (ready_cnt_last) state_next = ST_OPERATE;
            ST_OPERATE: if (end_feature_i) state_next = ST_DRAIN;
            ST_DRAIN: begin
                if (drain_cnt_last) begin
                    state_next = more_rounds ? ST_CLEAR : ST_DONE;
                end
            end
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
        if (abort_i && (state_q != ST_IDLE)) begin
            state_next = ST_IDLE;
        end
    end

    // Counters sit at zero through CLEAR and IDLE, and are loaded on the
    // edge that enters their phase so the first phase cycle sees the full count.
    assign cnt_clear      = (state_next == ST_CLEAR) || (state_next == ST_IDLE);
    assign load_cnt_load  = (state_q == ST_CLEAR) && (state_next == ST_LOAD);
    assign ready_cnt_load = (state_q == ST_LOAD) && (state_next == ST_READY);
    assign drain_cnt_load = (state_q == ST_OPERATE) && (state_next == ST_DRAIN);

    phase_counter #(.WIDTH(LOAD_W)) u_load_cnt (
        .clk        (clk_i),
        .rst        (general_rst_i),
        .clear      (cnt_clear),
        .load       (load_cnt_load),
        .load_value (load_total),
        .dec        ((state_q == ST_LOAD) && load_o),
        .last       (load_cnt_last)
    );

    phase_counter #(.WIDTH(READY_W)) u_ready_cnt (
        .clk        (clk_i),
        .rst        (general_rst_i),
        .clear      (cnt_clear),
        .load       (ready_cnt_load),
        .load_value (READY_W'(READY_CYCLES)),
        .dec        (state_q == ST_READY),
        .last       (ready_cnt_last)
    );

    phase_counter #(.WIDTH(DRAIN_W)) u_drain_cnt (
        .clk        (clk_i),
        .rst        (general_rst_i),
        .clear      (cnt_clear),
        .load       (drain_cnt_load),
        .load_value (drain_total),
        .dec        (state_q == ST_DRAIN),
        .last       (drain_cnt_last)
    );

    always_ff @(posedge clk_i) begin
        if (general_rst_i) begin
            state_q             <= ST_IDLE;
            fs_q                <= '0;
            rounds_q            <= '0;
            rst_o               <= 1'b0;
            load_o              <= 1'b0;
            ready_o             <= 1'b0;
            start_op_o          <= 1'b0;
            rd_weight_ld_o      <= 1'b0;
            rd_feature_ld_o     <= 1'b0;
            rd_rom_signals_ld_o <= 1'b0;
            addrs_rom_signal_o  <= '0;
            round_o             <= '0;
            busy_o              <= 1'b0;
            done_o              <= 1'b0;
            err_o               <= 1'b0;
        end else begin
            state_q <= state_next;

            if (start_accept) begin
                fs_q     <= filter_size_i;
                rounds_q <= (n_rounds_i == '0) ? COUNTER_ROUND_WIDTH'(1) : n_rounds_i;
            end

            rst_o               <= (state_next == ST_CLEAR);
            load_o              <= (state_next == ST_LOAD) && weight_valid_i;
            ready_o             <= (state_next == ST_READY);
            start_op_o          <= (state_next == ST_OPERATE);
            rd_weight_ld_o      <= (state_next == ST_LOAD);
            rd_feature_ld_o     <= (state_next == ST_OPERATE);
            rd_rom_signals_ld_o <= (state_next == ST_OPERATE);
            busy_o              <= (state_next != ST_IDLE);
            done_o              <= (state_next == ST_DONE);
            err_o               <= (state_q == ST_IDLE) && start_i && !cfg_ok;

            // Address steps on every OPERATE cycle, including the end_feature
            // cycle, and holds through DRAIN/DONE until the next CLEAR or IDLE.
            if ((state_next == ST_IDLE) || (state_next == ST_CLEAR)) begin
                addrs_rom_signal_o <= '0;
            end else if (state_q == ST_OPERATE) begin
                addrs_rom_signal_o <= addrs_rom_signal_o + SIG_ADDRS_WIDTH'(1);
            end

            if ((state_next == ST_IDLE) || start_accept) begin
                round_o <= '0;
            end else if (round_step) begin
                round_o <= round_o + COUNTER_ROUND_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_sa_round_sequencer.sv
// tb/tb_sa_round_sequencer.sv - self-checking bench for sa_round_sequencer
module tb_sa_round_sequencer;

    logic       clk = 1'b0;
    logic       general_rst_i = 1'b1;
    logic       start_i = 1'b0;
    logic       abort_i = 1'b0;
    logic [1:0] filter_size_i = '0;
    logic [2:0] n_rounds_i = '0;
    logic       weight_valid_i = 1'b0;
    logic       end_feature_i = 1'b0;

    logic       rst_o, load_o, ready_o, start_op_o;
    logic       rd_weight_ld_o, rd_feature_ld_o, rd_rom_signals_ld_o;
    logic [2:0] addrs_rom_signal_o;
    logic [2:0] round_o;
    logic       busy_o, done_o, err_o;

    always #5 clk = ~clk;

    sa_round_sequencer #(
        .N_ROWS_ARRAY        (4),
        .N_COLS_ARRAY        (4),
        .N                   (3),
        .SIG_ADDRS_WIDTH     (3),
        .COUNTER_ROUND_WIDTH (3),
        .READY_CYCLES        (2)
    ) dut (
        .clk_i               (clk),
        .general_rst_i       (general_rst_i),
        .start_i             (start_i),
        .abort_i             (abort_i),
        .filter_size_i       (filter_size_i),
        .n_rounds_i          (n_rounds_i),
        .weight_valid_i      (weight_valid_i),
        .end_feature_i       (end_feature_i),
        .rst_o               (rst_o),
        .load_o              (load_o),
        .ready_o             (ready_o),
        .start_op_o          (start_op_o),
        .rd_weight_ld_o      (rd_weight_ld_o),
        .rd_feature_ld_o     (rd_feature_ld_o),
        .rd_rom_signals_ld_o (rd_rom_signals_ld_o),
        .addrs_rom_signal_o  (addrs_rom_signal_o),
        .round_o             (round_o),
        .busy_o              (busy_o),
        .done_o              (done_o),
        .err_o               (err_o)
    );

    // {rst,load,ready,op,rd_w,rd_f,rd_rom,addr[2:0],round[2:0],busy,done,err}
    logic [15:0] act;
    assign act = {rst_o, load_o, ready_o, start_op_o, rd_weight_ld_o, rd_feature_ld_o,
                  rd_rom_signals_ld_o, addrs_rom_signal_o, round_o, busy_o, done_o, err_o};

    typedef struct {
        string       name;
        logic        rs, st, ab;
        logic [1:0]  fs;
        logic [2:0]  nr;
        logic        wv, ef;
        logic [15:0] exp;
    } vec_t;

    vec_t vq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Phase codes: 0 idle, 1 clear, 2 load, 3 ready, 4 operate, 5 drain, 6 done.
    function automatic logic [15:0] ex(int ph, bit ld, int addr, int rnd, bit err);
        logic [2:0] a;
        logic [2:0] r;
        a = 3'(addr);
        r = 3'(rnd);
        return {ph == 1, (ph == 2) && ld, ph == 3, ph == 4, ph == 2, ph == 4, ph == 4,
                a, r, ph != 0, ph == 6, err};
    endfunction

    function automatic void add(string nm, bit rs, bit st, bit ab, logic [1:0] fs,
                                logic [2:0] nr, bit wv, bit ef, logic [15:0] e);
        vec_t v;
        v.name = nm; v.rs = rs; v.st = st; v.ab = ab; v.fs = fs;
        v.nr = nr; v.wv = wv; v.ef = ef; v.exp = e;
        vq.push_back(v);
    endfunction

    task automatic chk(string nm, int got, int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, want);
        end
    endtask

    initial begin
        int  rst_cnt, load_cnt, ovl;
        bit  got_done;

        // Reset and idle
        add("reset",   1, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0));
        add("reset",   1, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0));
        add("idle",    0, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0));
        // Illegal filter size
        add("err_fs0", 0, 1, 0, 0, 1, 1, 0, ex(0, 0, 0, 0, 1));
        add("err_end", 0, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0));

        // Nominal: fs=3, one round, weights always valid
        add("nom_clear", 0, 1, 0, 3, 1, 1, 0, ex(1, 0, 0, 0, 0));
        for (int i = 0; i < 12; i++) add("nom_load",  0, 0, 0, 3, 1, 1, 0, ex(2, 1, 0, 0, 0));
        for (int i = 0; i < 2; i++)  add("nom_ready", 0, 0, 0, 3, 1, 1, 0, ex(3, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++)  add("nom_op",    0, 0, 0, 3, 1, 1, 0, ex(4, 0, i, 0, 0));
        add("nom_endf", 0, 0, 0, 3, 1, 1, 1, ex(5, 0, 3, 0, 0));
        for (int i = 0; i < 6; i++)  add("nom_drain", 0, 0, 0, 3, 1, 1, 0, ex(5, 0, 3, 0, 0));
        add("nom_done", 0, 0, 0, 3, 1, 1, 0, ex(6, 0, 3, 0, 0));
        add("nom_idle", 0, 0, 0, 3, 1, 1, 0, ex(0, 0, 0, 0, 0));

        // Address wrap with 3-bit ROM address; n_rounds=0 runs one round
        add("wrap_clear", 0, 1, 0, 1, 0, 1, 0, ex(1, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++)  add("wrap_load",  0, 0, 0, 1, 0, 1, 0, ex(2, 1, 0, 0, 0));
        for (int i = 0; i < 2; i++)  add("wrap_ready", 0, 0, 0, 1, 0, 1, 0, ex(3, 0, 0, 0, 0));
        for (int i = 0; i < 10; i++) add("wrap_op",    0, 0, 0, 1, 0, 1, 0, ex(4, 0, i % 8, 0, 0));
        add("wrap_endf", 0, 0, 0, 1, 0, 1, 1, ex(5, 0, 2, 0, 0));
        for (int i = 0; i < 4; i++)  add("wrap_drain", 0, 0, 0, 1, 0, 1, 0, ex(5, 0, 2, 0, 0));
        add("wrap_done", 0, 0, 0, 1, 0, 1, 0, ex(6, 0, 2, 0, 0));
        add("wrap_idle", 0, 0, 0, 1, 0, 1, 0, ex(0, 0, 0, 0, 0));

        // Three rounds, fs=1; a start during LOAD must be ignored
        for (int r = 0; r < 3; r++) begin
            add("r3_clear", 0, r == 0, 0, 1, 3, 1, 0, ex(1, 0, 0, r, 0));
            for (int i = 0; i < 4; i++)
                add("r3_load", 0, (r == 0) && (i == 1), 0, ((r == 0) && (i == 1)) ? 2'd0 : 2'd1,
                    3, 1, 0, ex(2, 1, 0, r, 0));
            for (int i = 0; i < 2; i++) add("r3_ready", 0, 0, 0, 1, 3, 1, 0, ex(3, 0, 0, r, 0));
            for (int i = 0; i < 2; i++) add("r3_op",    0, 0, 0, 1, 3, 1, 0, ex(4, 0, i, r, 0));
            add("r3_endf", 0, 0, 0, 1, 3, 1, 1, ex(5, 0, 2, r, 0));
            for (int i = 0; i < 4; i++) add("r3_drain", 0, 0, 0, 1, 3, 1, 0, ex(5, 0, 2, r, 0));
        end
        add("r3_done", 0, 0, 0, 1, 3, 1, 0, ex(6, 0, 2, 2, 0));
        add("r3_idle", 0, 0, 0, 1, 3, 1, 0, ex(0, 0, 0, 0, 0));

        // Alternating weight_valid: 12 beats over 24 LOAD cycles, then abort+end_feature
        add("tog_clear", 0, 1, 0, 3, 1, 0, 0, ex(1, 0, 0, 0, 0));
        for (int j = 1; j <= 24; j++)
            add("tog_load", 0, 0, 0, 3, 1, (j % 2) == 0, 0, ex(2, (j % 2) == 0, 0, 0, 0));
        for (int i = 0; i < 2; i++) add("tog_ready", 0, 0, 0, 3, 1, 0, 0, ex(3, 0, 0, 0, 0));
        add("tog_op",    0, 0, 0, 3, 1, 0, 0, ex(4, 0, 0, 0, 0));
        add("tog_abort", 0, 0, 1, 3, 1, 0, 1, ex(0, 0, 0, 0, 0));
        add("tog_idle",  0, 0, 0, 3, 1, 0, 0, ex(0, 0, 0, 0, 0));

        // Reset mid-LOAD, reset beats abort and start
        add("rl_clear", 0, 1, 0, 2, 1, 1, 0, ex(1, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) add("rl_load", 0, 0, 0, 2, 1, 1, 0, ex(2, 1, 0, 0, 0));
        add("rl_reset",       1, 1, 1, 2, 1, 1, 1, ex(0, 0, 0, 0, 0));
        add("rl_reset_start", 1, 1, 0, 0, 1, 1, 0, ex(0, 0, 0, 0, 0));
        add("rl_idle",        0, 0, 0, 2, 1, 0, 0, ex(0, 0, 0, 0, 0));

        for (int i = 0; i < vq.size(); i++) begin
            general_rst_i  = vq[i].rs;
            start_i        = vq[i].st;
            abort_i        = vq[i].ab;
            filter_size_i  = vq[i].fs;
            n_rounds_i     = vq[i].nr;
            weight_valid_i = vq[i].wv;
            end_feature_i  = vq[i].ef;
            @(posedge clk);
            #1;
            n_tests++;
            if (act !== vq[i].exp) begin
                n_fail++;
                $display("FAIL %s row %0d: got %h expected %h", vq[i].name, i, act, vq[i].exp);
            end
        end

        // Two rounds with random weight/end_feature timing
        general_rst_i = 1'b0; abort_i = 1'b0; end_feature_i = 1'b0;
        start_i = 1'b1; filter_size_i = 2'd2; n_rounds_i = 3'd2; weight_valid_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        rst_cnt = 0; load_cnt = 0; ovl = 0; got_done = 0;
        for (int c = 0; c < 600; c++) begin
            rst_cnt  += int'(rst_o);
            load_cnt += int'(load_o);
            if ((int'(rst_o) + int'(load_o) + int'(ready_o) + int'(start_op_o)) > 1) ovl++;
            if (done_o) begin
                got_done = 1;
                break;
            end
            weight_valid_i = 1'($urandom_range(0, 1));
            end_feature_i  = start_op_o && ($urandom_range(0, 3) == 0);
            @(posedge clk);
            #1;
        end
        chk("rand_done_seen", int'(got_done), 1);
        chk("rand_rst_pulses", rst_cnt, 2);
        chk("rand_load_beats", load_cnt, 16);
        chk("rand_overlap", ovl, 0);
        weight_valid_i = 1'b0; end_feature_i = 1'b0;
        @(posedge clk);
        #1;
        chk("rand_idle_busy", int'(busy_o), 0);
        chk("rand_idle_done", int'(done_o), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
